// File: rtl/spart_pkg.sv
// spart_pkg: shared types and constants for the SPART receiver and transmitter
package spart_pkg;
   localparam int SPART_OVERSAMPLE = 16;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/spart_sync.sv
// spart_sync: parameterised-width 2-flop synchronizer, resets to all ones
module spart_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] m;
   always_ff @(posedge clk) begin
      if (rst) begin
         m <= '1;
         q <= '1;
      end else begin
         m <= d;
         q <= m;
      end
   end
endmodule

// File: rtl/spart_rx.sv
// spart_rx: oversampled 8N1 serial receiver with data-available and sticky error flags
module spart_rx
   import spart_pkg::*;
#(
   parameter int OVERSAMPLE = SPART_OVERSAMPLE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_enable,
   input  logic       rxd,
   input  logic       read,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       framing_err,
   output logic       overrun_err
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
   rx_state_t state, state_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [2:0] bcnt, bcnt_n;
   logic [7:0] sr, sr_n, data_n;
   logic rda_n, fe_n, oe_n, rxd_s;
   spart_sync #(.W(1)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));
   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      bcnt_n  = bcnt;
      sr_n    = sr;
      data_n  = rx_data;
      rda_n   = rda & ~read;
      fe_n    = framing_err & ~read;
      oe_n    = overrun_err & ~read;
      if (rx_enable) begin
         case (state)
            IDLE: begin
               state_n = rxd_s ? IDLE : START;
               tcnt_n  = '0;
            end
            START: begin
               tcnt_n = (tcnt == HALF) ? '0 : tcnt + 1'b1;
               bcnt_n = '0;
               if (tcnt == HALF) state_n = rxd_s ? IDLE : DATA;
            end
            DATA: begin
               tcnt_n = (tcnt == LAST) ? '0 : tcnt + 1'b1;
               if (tcnt == LAST) begin
                  sr_n    = {rxd_s, sr[7:1]};
                  bcnt_n  = bcnt + 3'd1;
                  state_n = (bcnt == 3'd7) ? STOP : DATA;
               end
            end
            STOP: begin
               tcnt_n = (tcnt == LAST) ? '0 : tcnt + 1'b1;
               // a completing byte wins over a simultaneous read
               if (tcnt == LAST) begin
                  data_n  = sr;
                  rda_n   = 1'b1;
                  fe_n    = (framing_err & ~read) | ~rxd_s;
                  oe_n    = ~read & (overrun_err | rda);
                  state_n = IDLE;
               end
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tcnt        <= '0;
         bcnt        <= '0;
         sr          <= 8'hFF;
         rx_data     <= 8'hFF;
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state       <= state_n;
         tcnt        <= tcnt_n;
         bcnt        <= bcnt_n;
         sr          <= sr_n;
         rx_data     <= data_n;
         rda         <= rda_n;
         framing_err <= fe_n;
         overrun_err <= oe_n;
      end
   end
endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed self-checking bench for spart_rx at 16x oversampling
module tb_spart_rx;
   logic clk = 1'b0, rst = 1'b1, rx_enable = 1'b1, rxd = 1'b1, read = 1'b0;
   logic [7:0] rx_data;
   logic rda, framing_err, overrun_err;
   int n_checks = 0, n_fail = 0, rise;
   logic [9:0] fr;

   spart_rx #(.OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .rx_enable(rx_enable), .rxd(rxd), .read(read),
      .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drives one frame, 16 clk per bit; read is high during the clk of index rd_cycle
   task automatic send(input logic [7:0] d, input logic stop, input int rd_cycle, output int r);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      r = -1;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         if (r < 0 && rda) r = i;
         rxd  = f[i/16];
         read = (i == rd_cycle);
      end
      read = 1'b0;
   endtask

   task automatic pulse_read();
      @(negedge clk) read = 1'b1;
      @(negedge clk) read = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(rx_data), 32'hFF);
      chk("rst_rda", 32'(rda), 0);
      chk("rst_fe", 32'(framing_err), 0);
      chk("rst_oe", 32'(overrun_err), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      send(8'h22, 1'b1, -1, rise);
      chk("lat_22", 32'(rise), 155);
      chk("data_22", 32'(rx_data), 32'h22);
      chk("rda_22", 32'(rda), 1);
      chk("fe_22", 32'(framing_err), 0);
      chk("oe_22", 32'(overrun_err), 0);
      pulse_read();
      chk("read_clr", 32'(rda), 0);

      send(8'hA5, 1'b1, -1, rise);
      chk("data_a5", 32'(rx_data), 32'hA5);
      chk("rda_a5", 32'(rda), 1);
      send(8'h5A, 1'b1, 2, rise);
      chk("data_5a", 32'(rx_data), 32'h5A);
      chk("rda_5a", 32'(rda), 1);
      chk("oe_5a", 32'(overrun_err), 0);
      pulse_read();

      @(negedge clk) rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_idle", 32'(dut.state), 0);
      chk("glitch_rda", 32'(rda), 0);
      send(8'h3C, 1'b1, -1, rise);
      chk("data_3c", 32'(rx_data), 32'h3C);
      chk("rda_3c", 32'(rda), 1);
      pulse_read();

      send(8'hFF, 1'b0, -1, rise);
      rxd = 1'b1;
      chk("data_ff", 32'(rx_data), 32'hFF);
      chk("rda_ff", 32'(rda), 1);
      chk("fe_ff", 32'(framing_err), 1);
      chk("oe_ff", 32'(overrun_err), 0);
      repeat (20) @(negedge clk);
      pulse_read();
      chk("fe_clr_rda", 32'(rda), 0);
      chk("fe_clr_fe", 32'(framing_err), 0);
      chk("fe_clr_oe", 32'(overrun_err), 0);

      send(8'h11, 1'b1, -1, rise);
      send(8'h22, 1'b1, -1, rise);
      chk("ovr_data", 32'(rx_data), 32'h22);
      chk("ovr_rda", 32'(rda), 1);
      chk("ovr_oe", 32'(overrun_err), 1);
      chk("ovr_fe", 32'(framing_err), 0);
      pulse_read();
      chk("ovr_clr", 32'(overrun_err), 0);
      send(8'h11, 1'b1, -1, rise);
      send(8'h22, 1'b1, 154, rise);
      chk("coin_rda", 32'(rda), 1);
      chk("coin_oe", 32'(overrun_err), 0);
      chk("coin_data", 32'(rx_data), 32'h22);
      pulse_read();

      fr = {1'b1, 8'hC3, 1'b0};
      for (int i = 0; i < 88; i++) begin
         @(negedge clk);
         rxd = fr[i/16];
      end
      @(negedge clk);
      rst = 1'b1;
      rxd = 1'b1;
      @(negedge clk) rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_rda", 32'(rda), 0);
      chk("abort_data", 32'(rx_data), 32'hFF);
      chk("abort_idle", 32'(dut.state), 0);
      send(8'h81, 1'b1, -1, rise);
      chk("data_81", 32'(rx_data), 32'h81);
      chk("rda_81", 32'(rda), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
